// File: rtl/rgmii_tx_scheduler.sv
// rgmii_tx_scheduler
// Round-robin arbiter and byte-slot sequencer for the RGMII/UDP transmit path.
// One payload source is granted at a time. The block then steps through the
// frame phases, one byte slot per byte_ready_i strobe.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   req_i, len_i         per-source request level and payload length (16b each)
//   byte_ready_i         datapath consumes one byte slot this cycle
//   grant_o              one-hot grant, held from PREAMBLE through IFG
//   reject_o             one-cycle pulse for an oversize request
//   payload_rd_o         payload byte pop strobe (combinational on byte_ready_i)
//   phase_o, byte_idx_o  current phase and byte index within it
//   last_o               current slot is the final slot of the phase
//   ip_total_length_o    28 + len, registered at grant
//   udp_length_o         8 + len, registered at grant
//   done_o               one-cycle pulse when the IFG finishes
//
// phase    | meaning
// IDLE     | arbitrating, no grant
// PREAMBLE | 7 preamble bytes
// SFD      | start-of-frame delimiter
// HEADER   | 42-byte Ethernet/IPv4/UDP header
// PAYLOAD  | len payload bytes (skipped when len = 0)
// PAD      | pad bytes up to the minimum frame (skipped when not needed)
// FCS      | 4-byte frame check sequence
// IFG      | inter-frame gap
module rgmii_tx_scheduler #(
  parameter int NUM_CH            = 4,
  parameter int MAX_PAYLOAD_BYTES = 1472,
  parameter int MIN_PAYLOAD_BYTES = 18,
  parameter int IFG_BYTES         = 12
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_CH-1:0]      req_i,
  input  logic [NUM_CH*16-1:0]   len_i,
  input  logic                   byte_ready_i,
  output logic [NUM_CH-1:0]      grant_o,
  output logic [NUM_CH-1:0]      reject_o,
  output logic [NUM_CH-1:0]      payload_rd_o,
  output logic [2:0]             phase_o,
  output logic [10:0]            byte_idx_o,
  output logic                   last_o,
  output logic [15:0]            ip_total_length_o,
  output logic [15:0]            udp_length_o,
  output logic                   done_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [2:0] {
    PH_IDLE     = 3'd0,
    PH_PREAMBLE = 3'd1,
    PH_SFD      = 3'd2,
    PH_HEADER   = 3'd3,
    PH_PAYLOAD  = 3'd4,
    PH_PAD      = 3'd5,
    PH_FCS      = 3'd6,
    PH_IFG      = 3'd7
  } phase_t;

  phase_t            phase_q, phase_d;
  logic [10:0]       byte_idx_q, byte_idx_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       ip_len_q, ip_len_d;
  logic [15:0]       udp_len_q, udp_len_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic [NUM_CH-1:0] reject_q, reject_d;
  logic              done_q, done_d;
  logic [CH_W-1:0]   last_ch_q, last_ch_d;

  // Round-robin search: first requester after last_ch, wrapping.
  logic              found;
  logic [CH_W-1:0]   win;
  logic [15:0]       win_len;
  logic [NUM_CH-1:0] win_oh;
  int                cand;

  always_comb begin
    found   = 1'b0;
    win     = last_ch_q;
    win_len = '0;
    cand    = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = int'(last_ch_q) + i;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (!found && req_i[cand[CH_W-1:0]]) begin
        found = 1'b1;
        win   = cand[CH_W-1:0];
      end
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (win == CH_W'(c)) win_len = len_i[c*16 +: 16];
    end
    win_oh = NUM_CH'(1) << win;
  end

  // Per-phase slot count; a phase is never entered with a zero count.
  logic [15:0] pad_len;
  logic [15:0] phase_len;
  logic        last;
  phase_t      phase_nxt;

  always_comb begin
    pad_len = (len_q < 16'(MIN_PAYLOAD_BYTES)) ? (16'(MIN_PAYLOAD_BYTES) - len_q) : 16'd0;
    phase_len = 16'd0;
    phase_nxt = PH_IDLE;
    case (phase_q)
      PH_PREAMBLE: begin phase_len = 16'd7;  phase_nxt = PH_SFD;    end
      PH_SFD:      begin phase_len = 16'd1;  phase_nxt = PH_HEADER; end
      PH_HEADER: begin
        phase_len = 16'd42;
        if (len_q != 16'd0)        phase_nxt = PH_PAYLOAD;
        else if (pad_len != 16'd0) phase_nxt = PH_PAD;
        else                       phase_nxt = PH_FCS;
      end
      PH_PAYLOAD: begin
        phase_len = len_q;
        phase_nxt = (pad_len != 16'd0) ? PH_PAD : PH_FCS;
      end
      PH_PAD:      begin phase_len = pad_len;          phase_nxt = PH_FCS;  end
      PH_FCS:      begin phase_len = 16'd4;            phase_nxt = PH_IFG;  end
      PH_IFG:      begin phase_len = 16'(IFG_BYTES);   phase_nxt = PH_IDLE; end
      default:     begin phase_len = 16'd0;            phase_nxt = PH_IDLE; end
    endcase
    last = (phase_q != PH_IDLE) && ({5'd0, byte_idx_q} == (phase_len - 16'd1));
  end

  always_comb begin
    phase_d    = phase_q;
    byte_idx_d = byte_idx_q;
    len_d      = len_q;
    ip_len_d   = ip_len_q;
    udp_len_d  = udp_len_q;
    grant_d    = grant_q;
    reject_d   = '0;
    done_d     = 1'b0;
    last_ch_d  = last_ch_q;

    if (phase_q == PH_IDLE) begin
      if (found) begin
        last_ch_d = win;
        if (win_len > 16'(MAX_PAYLOAD_BYTES)) begin
          reject_d = win_oh;
        end else begin
          grant_d    = win_oh;
          len_d      = win_len;
          ip_len_d   = win_len + 16'd28;
          udp_len_d  = win_len + 16'd8;
          phase_d    = PH_PREAMBLE;
          byte_idx_d = 11'd0;
        end
      end
    end else if (byte_ready_i) begin
      if (last) begin
        byte_idx_d = 11'd0;
        phase_d    = phase_nxt;
        if (phase_q == PH_IFG) begin
          grant_d = '0;
          done_d  = 1'b1;
        end
      end else begin
        byte_idx_d = byte_idx_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phase_q    <= PH_IDLE;
      byte_idx_q <= '0;
      len_q      <= '0;
      ip_len_q   <= '0;
      udp_len_q  <= '0;
      grant_q    <= '0;
      reject_q   <= '0;
      done_q     <= 1'b0;
      last_ch_q  <= CH_W'(NUM_CH - 1);
    end else begin
      phase_q    <= phase_d;
      byte_idx_q <= byte_idx_d;
      len_q      <= len_d;
      ip_len_q   <= ip_len_d;
      udp_len_q  <= udp_len_d;
      grant_q    <= grant_d;
      reject_q   <= reject_d;
      done_q     <= done_d;
      last_ch_q  <= last_ch_d;
    end
  end

  assign grant_o           = grant_q;
  assign reject_o          = reject_q;
  assign payload_rd_o      = grant_q & {NUM_CH{(phase_q == PH_PAYLOAD) && byte_ready_i}};
  assign phase_o           = phase_q;
  assign byte_idx_o        = byte_idx_q;
  assign last_o            = last;
  assign ip_total_length_o = ip_len_q;
  assign udp_length_o      = udp_len_q;
  assign done_o            = done_q;

endmodule

// File: tb/tb_rgmii_tx_scheduler.sv
// Self-checking bench for rgmii_tx_scheduler. The reference expands each
// frame into its list of byte slots (phase, index, last flag) from the phase
// lengths, and tracks round-robin priority with a plain last-channel integer.
module tb_rgmii_tx_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_i;
  logic [63:0] len_i;
  logic        byte_ready_i;
  logic [3:0]  grant_o;
  logic [3:0]  reject_o;
  logic [3:0]  payload_rd_o;
  logic [2:0]  phase_o;
  logic [10:0] byte_idx_o;
  logic        last_o;
  logic [15:0] ip_total_length_o;
  logic [15:0] udp_length_o;
  logic        done_o;

  always #5 clk_i = ~clk_i;

  rgmii_tx_scheduler #(
    .NUM_CH(4), .MAX_PAYLOAD_BYTES(1472), .MIN_PAYLOAD_BYTES(18), .IFG_BYTES(12)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .len_i(len_i),
    .byte_ready_i(byte_ready_i), .grant_o(grant_o), .reject_o(reject_o),
    .payload_rd_o(payload_rd_o), .phase_o(phase_o), .byte_idx_o(byte_idx_o),
    .last_o(last_o), .ip_total_length_o(ip_total_length_o),
    .udp_length_o(udp_length_o), .done_o(done_o)
  );

  int total = 0;
  int bad   = 0;
  int last_ch_m;
  int ph_q[$];
  int ix_q[$];
  int ls_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic set_len(input int ch, input int v);
    len_i[ch*16 +: 16] = 16'(v);
  endtask

  function automatic int len_of(input int ch);
    return int'(len_i[ch*16 +: 16]);
  endfunction

  function automatic int pick(input logic [3:0] r);
    int c;
    for (int k = 1; k <= 4; k++) begin
      c = (last_ch_m + k) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  task automatic push_phase(input int p, input int n);
    for (int k = 0; k < n; k++) begin
      ph_q.push_back(p);
      ix_q.push_back(k);
      ls_q.push_back((k == n - 1) ? 1 : 0);
    end
  endtask

  task automatic reset_dut();
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    last_ch_m = 3;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_phase"},  32'(phase_o), 0);
    check_eq({tag, "_grant"},  32'(grant_o), 0);
    check_eq({tag, "_reject"}, 32'(reject_o), 0);
    check_eq({tag, "_done"},   32'(done_o), 0);
    check_eq({tag, "_idx"},    32'(byte_idx_o), 0);
    check_eq({tag, "_ip"},     32'(ip_total_length_o), 0);
    check_eq({tag, "_udp"},    32'(udp_length_o), 0);
    check_eq({tag, "_last"},   32'(last_o), 0);
    check_eq({tag, "_rd"},     32'(payload_rd_o), 0);
  endtask

  // Starts in IDLE at a falling edge with the request already presented.
  task automatic run_frame(input int ch, input int len, input bit stall, input bit drop);
    int  pad;
    int  rd_cnt;
    int  budget;
    bit  br;
    tick();
    check_eq("grant", 32'(grant_o), 1 << ch);
    check_eq("phase_start", 32'(phase_o), 1);
    check_eq("idx_start", 32'(byte_idx_o), 0);
    check_eq("ip_len", 32'(ip_total_length_o), 28 + len);
    check_eq("udp_len", 32'(udp_length_o), 8 + len);
    check_eq("reject_clr", 32'(reject_o), 0);
    check_eq("done_clr", 32'(done_o), 0);
    last_ch_m = ch;
    if (drop) begin
      req_i[ch] = 1'b0;
      set_len(ch, int'($urandom_range(0, 65535)));
    end
    pad = (len < 18) ? 18 - len : 0;
    ph_q.delete(); ix_q.delete(); ls_q.delete();
    push_phase(1, 7);
    push_phase(2, 1);
    push_phase(3, 42);
    push_phase(4, len);
    push_phase(5, pad);
    push_phase(6, 4);
    push_phase(7, 12);
    rd_cnt = 0;
    budget = 20000;
    while (ph_q.size() > 0 && budget > 0) begin
      br = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      byte_ready_i = br;
      #1;
      check_eq("phase", 32'(phase_o), ph_q[0]);
      check_eq("byte_idx", 32'(byte_idx_o), ix_q[0]);
      check_eq("last", 32'(last_o), ls_q[0]);
      check_eq("grant_hold", 32'(grant_o), 1 << ch);
      check_eq("payload_rd", 32'(payload_rd_o), (br && ph_q[0] == 4) ? (1 << ch) : 0);
      if (payload_rd_o[ch]) rd_cnt++;
      tick();
      if (br) begin
        void'(ph_q.pop_front());
        void'(ix_q.pop_front());
        void'(ls_q.pop_front());
      end
      budget--;
    end
    check_eq("frame_slots_left", ph_q.size(), 0);
    byte_ready_i = 1'b1;
    check_eq("done", 32'(done_o), 1);
    check_eq("phase_end", 32'(phase_o), 0);
    check_eq("grant_end", 32'(grant_o), 0);
    check_eq("rd_count", rd_cnt, len);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ch;
    int ln;
    rst_i = 1'b1;
    req_i = '0;
    len_i = '0;
    byte_ready_i = 1'b0;
    last_ch_m = 3;
    repeat (2) @(negedge clk_i);
    check_reset_vals("rst");
    rst_i = 1'b0;
    byte_ready_i = 1'b1;

    // Single frame, then pad cases.
    req_i[1] = 1'b1; set_len(1, 100);
    run_frame(pick(req_i), 100, 1'b0, 1'b1);
    req_i[2] = 1'b1; set_len(2, 5);
    run_frame(pick(req_i), 5, 1'b0, 1'b1);
    req_i[3] = 1'b1; set_len(3, 0);
    run_frame(pick(req_i), 0, 1'b0, 1'b1);
    req_i[0] = 1'b1; set_len(0, 40);
    run_frame(pick(req_i), 40, 1'b1, 1'b1);

    // Round robin with all four requesting continuously.
    reset_dut();
    for (int c = 0; c < 4; c++) set_len(c, int'($urandom_range(0, 40)));
    req_i = 4'hf;
    for (int f = 0; f < 5; f++) begin
      ch = pick(req_i);
      run_frame(ch, len_of(ch), 1'b0, 1'b0);
    end
    req_i = '0;

    // Oversize rejection, then the limit length is accepted.
    reset_dut();
    set_len(2, 1473); set_len(3, 20);
    req_i = 4'b1100;
    ch = pick(req_i);
    tick();
    check_eq("reject", 32'(reject_o), 1 << ch);
    check_eq("reject_nogrant", 32'(grant_o), 0);
    check_eq("reject_phase", 32'(phase_o), 0);
    last_ch_m = ch;
    req_i[ch] = 1'b0;
    run_frame(pick(req_i), 20, 1'b0, 1'b1);
    set_len(2, 1472); req_i[2] = 1'b1;
    run_frame(pick(req_i), 1472, 1'b0, 1'b1);

    // Randomized traffic with occasional oversize requests and stalls.
    for (int it = 0; it < 30; it++) begin
      if (req_i == '0) begin
        req_i = 4'($urandom_range(1, 15));
        for (int c = 0; c < 4; c++)
          set_len(c, ($urandom_range(0, 9) == 0) ? 1473 + int'($urandom_range(0, 100))
                                                 : int'($urandom_range(0, 60)));
      end
      ch = pick(req_i);
      ln = len_of(ch);
      if (ln > 1472) begin
        tick();
        check_eq("rnd_reject", 32'(reject_o), 1 << ch);
        check_eq("rnd_reject_nogrant", 32'(grant_o), 0);
        last_ch_m = ch;
        req_i[ch] = 1'b0;
      end else begin
        run_frame(ch, ln, 1'($urandom_range(0, 1)), 1'b1);
      end
    end
    req_i = '0;
    byte_ready_i = 1'b1;

    // Reset in the middle of the payload.
    reset_dut();
    req_i = 4'b0010; set_len(1, 100);
    tick();
    check_eq("mid_grant", 32'(grant_o), 2);
    req_i = '0;
    for (int k = 0; k < 200; k++) begin
      if (phase_o == 3'd4 && byte_idx_o == 11'd30) break;
      tick();
    end
    check_eq("mid_at_phase", 32'(phase_o), 4);
    check_eq("mid_at_idx", 32'(byte_idx_o), 30);
    rst_i = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    req_i = 4'b0101; set_len(0, 10); set_len(2, 10);
    #2;
    rst_i = 1'b0;
    last_ch_m = 3;
    run_frame(pick(req_i), 10, 1'b0, 1'b1);
    run_frame(pick(req_i), 10, 1'b0, 1'b1);
    req_i = '0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
